// File: rtl/codec_cfg_seq.sv
// Power-up configuration sequencer for the audio codec: walks a fixed table of
// register writes through the I2C write engine, with spacing, retries and status.
module codec_cfg_seq #(
  parameter int unsigned NUM_REGS       = 11,
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        i2c_req,
  output logic [7:0]  i2c_addr,
  output logic [15:0] i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cfg_index
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 2);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, GAP, DONE, ERROR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic [15:0]        rom_word_c;

  // Register write table: {reg_addr[6:0], reg_data[8:0]}
  always_comb begin
    rom_word_c = 16'h0000;
    case (cfg_index)
      4'd0:    rom_word_c = 16'h1E00;
      4'd1:    rom_word_c = 16'h0C00;
      4'd2:    rom_word_c = 16'h0017;
      4'd3:    rom_word_c = 16'h0217;
      4'd4:    rom_word_c = 16'h0479;
      4'd5:    rom_word_c = 16'h0679;
      4'd6:    rom_word_c = 16'h0812;
      4'd7:    rom_word_c = 16'h0A00;
      4'd8:    rom_word_c = 16'h0E42;
      4'd9:    rom_word_c = 16'h1000;
      4'd10:   rom_word_c = 16'h1201;
      default: rom_word_c = 16'h0000;
    endcase
  end

  assign i2c_addr = DEV_ADDR;

  // One counter serves as the REQ timeout timer and the GAP spacing timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      retry     <= '0;
      i2c_req   <= 1'b0;
      i2c_wdata <= '0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      cfg_index <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= LOAD;
            cfg_index <= '0;
            retry     <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            cfg_busy  <= 1'b1;
          end
        end
        LOAD: begin
          i2c_wdata <= rom_word_c;
          cnt       <= '0;
          i2c_req   <= 1'b1;
          state     <= REQ;
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          // A done result takes priority over a coincident timeout
          if (i2c_done && !i2c_nack) begin
            i2c_req <= 1'b0;
            retry   <= '0;
            cnt     <= '0;
            if (cfg_index == LAST_IDX) begin
              state    <= DONE;
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
            end else begin
              cfg_index <= cfg_index + IDX_W'(1);
              state     <= GAP;
            end
          end else if (i2c_done || (cnt == TO_LAST)) begin
            i2c_req <= 1'b0;
            cnt     <= '0;
            if (retry < RETRY_LIM) begin
              retry <= retry + RETRY_W'(1);
              state <= GAP;
            end else begin
              state     <= ERROR;
              cfg_error <= 1'b1;
              cfg_busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed bench for codec_cfg_seq: a scripted I2C engine model answers each
// request; request order, spacing, retries, timeouts and status are checked.
`timescale 1ns/1ps
module tb_codec_cfg_seq;

  localparam int unsigned GAP  = 1000;
  localparam int unsigned TMO  = 500;
  localparam int unsigned NREG = 11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        i2c_req;
  logic [7:0]  i2c_addr;
  logic [15:0] i2c_wdata;
  logic        cfg_busy, cfg_done, cfg_error;
  logic [3:0]  cfg_index;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  logic [15:0] tbl [NREG] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                              16'h0679, 16'h0812, 16'h0A00, 16'h0E42, 16'h1000, 16'h1201};

  // Engine behaviour knobs
  int ack_delay = 200;
  int nack_idx  = -1;
  int nack_n    = 0;
  int mute_idx  = -1;
  int mute_n    = 0;
  int slow_idx  = -1;
  int attempts [NREG];

  logic [15:0] log_q [$];
  logic [15:0] exp_q [$];
  int          len_q [$];
  int unsigned rise_cyc = 0;
  int unsigned done_cyc = 0;
  bit          done_valid = 1'b0;

  codec_cfg_seq #(
    .NUM_REGS(11), .DEV_ADDR(8'h34), .RETRY_MAX(3),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .cfg_index(cfg_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int tbl_idx(input logic [15:0] w);
    for (int i = 0; i < int'(NREG); i++) if (tbl[i] == w) return i;
    return -1;
  endfunction

  // I2C engine model: logs each request and answers after a scripted delay
  initial begin : engine
    int age;
    int resp_at;
    int idx;
    bit nk;
    bit prev;
    age = 0; resp_at = 0; nk = 1'b0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        i2c_done = 1'b0; i2c_nack = 1'b0; prev = 1'b0; done_valid = 1'b0;
      end else begin
        if (i2c_req && !prev) begin
          idx = tbl_idx(i2c_wdata);
          log_q.push_back(i2c_wdata);
          if (done_valid) check("gap", 32'(cyc - done_cyc), 32'(GAP + 2));
          done_valid = 1'b0;
          rise_cyc   = cyc;
          age        = 0;
          resp_at    = ack_delay;
          nk         = 1'b0;
          if (idx >= 0) begin
            if (idx == nack_idx && attempts[idx] < nack_n) nk = 1'b1;
            if (idx == mute_idx && attempts[idx] < mute_n) resp_at = 0;
            if (idx == slow_idx && attempts[idx] == 0) resp_at = int'(TMO);
            attempts[idx]++;
          end
        end
        if (!i2c_req && prev) len_q.push_back(int'(cyc - rise_cyc));
        if (i2c_done) begin
          i2c_done = 1'b0; i2c_nack = 1'b0;
        end else if (i2c_req) begin
          age++;
          if (age == resp_at) begin
            i2c_done = 1'b1; i2c_nack = nk; done_cyc = cyc; done_valid = 1'b1;
          end
        end
        prev = i2c_req;
      end
    end
  end

  task automatic clear_run();
    log_q.delete(); len_q.delete();
    for (int i = 0; i < int'(NREG); i++) attempts[i] = 0;
    done_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(cfg_done || cfg_error) && n < 40000) begin @(negedge clk); n++; end
    if (n >= 40000) check({tag, "_timeout"}, 32'(0), 32'(1));
    @(negedge clk);
  endtask

  task automatic wait_reqs(input string tag, input int cnt);
    int n;
    n = 0;
    while (log_q.size() < cnt && n < 40000) begin @(negedge clk); n++; end
    if (n >= 40000) check({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic exp_full();
    exp_q.delete();
    for (int i = 0; i < int'(NREG); i++) exp_q.push_back(tbl[i]);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic [3:0] idx);
    check({tag, "_done"},  32'(cfg_done),  32'(d));
    check({tag, "_error"}, 32'(cfg_error), 32'(e));
    check({tag, "_busy"},  32'(cfg_busy),  32'(0));
    check({tag, "_index"}, 32'(cfg_index), 32'(idx));
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_req",   32'(i2c_req),   32'(0));
    check("rst_addr",  32'(i2c_addr),  32'h34);
    check("rst_wdata", 32'(i2c_wdata), 32'h0);
    check("rst_busy",  32'(cfg_busy),  32'(0));
    check("rst_done",  32'(cfg_done),  32'(0));
    check("rst_error", 32'(cfg_error), 32'(0));
    check("rst_index", 32'(cfg_index), 32'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run, engine answers after 200 cycles
    clear_run(); ack_delay = 200;
    pulse_start();
    check("clean_busy", 32'(cfg_busy), 32'(1));
    wait_end("clean");
    exp_full(); check_seq("clean");
    check("clean_len", 32'(len_q[0]), 32'(200));
    check_status("clean", 1'b1, 1'b0, 4'd10);

    // Single NACK on first attempt of index 3
    clear_run(); ack_delay = 20; nack_idx = 3; nack_n = 1;
    pulse_start();
    wait_end("nack1");
    exp_full(); exp_q.insert(3, 16'h0217); check_seq("nack1");
    check_status("nack1", 1'b1, 1'b0, 4'd10);

    // Every attempt at index 5 NACKed
    clear_run(); nack_idx = 5; nack_n = 99;
    pulse_start();
    wait_end("exh");
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(tbl[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0679);
    check_seq("exh");
    check_status("exh", 1'b0, 1'b1, 4'd5);
    repeat (1500) @(negedge clk);
    check("exh_quiet", 32'(log_q.size()), 32'(9));
    clear_run(); nack_idx = -1;
    pulse_start();
    wait_reqs("exh_restart", 2);
    check("exh_restart_0", 32'(log_q[0]), 32'h1E00);
    check("exh_restart_err", 32'(cfg_error), 32'(0));
    pulse_reset();

    // Engine never answers at index 0
    clear_run(); mute_idx = 0; mute_n = 99;
    pulse_start();
    wait_end("tmo");
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h1E00);
    check_seq("tmo");
    check("tmo_nlen", 32'(len_q.size()), 32'(4));
    for (int i = 0; i < len_q.size(); i++) check($sformatf("tmo_len_%0d", i), 32'(len_q[i]), 32'(TMO));
    check_status("tmo", 1'b0, 1'b1, 4'd0);

    // done landing on the timeout cycle is a success
    clear_run(); mute_idx = -1; slow_idx = 0;
    pulse_start();
    wait_reqs("coinc", 2);
    check("coinc_next", 32'(log_q[1]), 32'h0C00);
    check("coinc_len", 32'(len_q[0]), 32'(TMO));
    slow_idx = -1;
    pulse_reset();

    // start pulse while busy is ignored
    clear_run();
    pulse_start();
    wait_reqs("busy", 5);
    repeat (3) @(negedge clk);
    check("busy_idx4", 32'(cfg_index), 32'(4));
    pulse_start();
    wait_end("busy");
    exp_full(); check_seq("busy");
    check_status("busy", 1'b1, 1'b0, 4'd10);

    // Asynchronous reset while index 7 is in REQ
    clear_run();
    pulse_start();
    wait_reqs("rstm", 8);
    repeat (3) @(negedge clk);
    check("rstm_at7", 32'(log_q[7]), 32'h0A00);
    check("rstm_req_before", 32'(i2c_req), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rstm_req",   32'(i2c_req),   32'(0));
    check("rstm_busy",  32'(cfg_busy),  32'(0));
    check("rstm_done",  32'(cfg_done),  32'(0));
    check("rstm_error", 32'(cfg_error), 32'(0));
    check("rstm_index", 32'(cfg_index), 32'(0));
    check("rstm_wdata", 32'(i2c_wdata), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (1500) @(negedge clk);
    check("rstm_quiet", 32'(log_q.size()), 32'(8));
    clear_run();
    pulse_start();
    wait_end("rstm_run");
    exp_full(); check_seq("rstm_run");
    check_status("rstm_run", 1'b1, 1'b0, 4'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
